// File: rtl/lsu_mem_port_if.sv
// Core-side request/response and data-memory signals of the load/store unit.
// master = core plus memory environment, slave = lsu_mem_port.
interface lsu_mem_port_if;
    localparam int unsigned XLEN = 32;

    logic            req;
    logic            we;
    logic [2:0]      funct3;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic            ready;
    logic            done;
    logic [XLEN-1:0] rdata;
    logic            misaligned;
    logic            mem_read;
    logic            mem_write;
    logic [XLEN-1:0] mem_address;
    logic [XLEN-1:0] mem_write_data;
    logic [XLEN-1:0] mem_read_data;

    modport master (
        output req, we, funct3, addr, wdata, mem_read_data,
        input  ready, done, rdata, misaligned,
        input  mem_read, mem_write, mem_address, mem_write_data
    );

    modport slave (
        input  req, we, funct3, addr, wdata, mem_read_data,
        output ready, done, rdata, misaligned,
        output mem_read, mem_write, mem_address, mem_write_data
    );
endinterface

// File: rtl/lsu_mem_port.sv
// Load/store unit: byte/half/word core accesses onto a word-organised memory,
// sub-word stores by read-modify-write. Optional LSU_MISALIGN_TRAP_EN rejects misaligned accesses.
module lsu_mem_port (
    input  logic           clk,
    input  logic           rst_n,
    lsu_mem_port_if.slave  io_lsu
);
    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR, ST_DONE} state_e;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

    state_e          r_state, w_state_nxt;
    logic            r_we, w_we_nxt;
    size_e           r_size, w_size_nxt;
    logic            r_uns, w_uns_nxt;
    logic [1:0]      r_off, w_off_nxt;
    logic [15:0]     r_wdata, w_wdata_nxt;
    logic            r_ready, r_done, r_mem_read, r_mem_write, r_mis, w_mis_nxt;
    logic [XLEN-1:0] r_rdata, w_rdata_nxt;
    logic [XLEN-1:0] r_maddr, w_maddr_nxt;
    logic [XLEN-1:0] r_mwdata, w_mwdata_nxt;
    size_e           w_req_size;
    logic            w_req_mis;

    // Pick the addressed lane and extend it to a full word.
    function automatic logic [XLEN-1:0] lane_extract(input logic [XLEN-1:0] word,
                                                     input size_e size, input logic [1:0] off,
                                                     input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_B:    return uns ? {24'h0, b} : {{24{b[7]}}, b};
            SZ_H:    return uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: return word;
        endcase
    endfunction

    // Replace only the addressed lane(s) of the word read back in RD.
    function automatic logic [XLEN-1:0] lane_merge(input logic [XLEN-1:0] word,
                                                   input size_e size, input logic [1:0] off,
                                                   input logic [15:0] d);
        case (size)
            SZ_B: begin
                case (off)
                    2'd0:    return {word[31:8], d[7:0]};
                    2'd1:    return {word[31:16], d[7:0], word[7:0]};
                    2'd2:    return {word[31:24], d[7:0], word[15:0]};
                    default: return {d[7:0], word[23:0]};
                endcase
            end
            SZ_H:    return off[1] ? {d, word[15:0]} : {word[31:16], d};
            default: return word;
        endcase
    endfunction

    // Store funct3[2] is don't-care; unknown load encodings fall back to word.
    always_comb begin
        w_req_size = SZ_W;
        if (io_lsu.we) begin
            case (io_lsu.funct3[1:0])
                2'b00:   w_req_size = SZ_B;
                2'b01:   w_req_size = SZ_H;
                default: w_req_size = SZ_W;
            endcase
        end else begin
            case (io_lsu.funct3)
                3'b000, 3'b100: w_req_size = SZ_B;
                3'b001, 3'b101: w_req_size = SZ_H;
                default:        w_req_size = SZ_W;
            endcase
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_req_mis = ((w_req_size == SZ_H) && io_lsu.addr[0]) ||
                       ((w_req_size == SZ_W) && (io_lsu.addr[1:0] != 2'b00));
`else
    assign w_req_mis = 1'b0;
`endif

    // Next-state and next-register values.
    always_comb begin
        w_state_nxt  = r_state;
        w_we_nxt     = r_we;
        w_size_nxt   = r_size;
        w_uns_nxt    = r_uns;
        w_off_nxt    = r_off;
        w_wdata_nxt  = r_wdata;
        w_rdata_nxt  = r_rdata;
        w_mis_nxt    = r_mis;
        w_maddr_nxt  = r_maddr;
        w_mwdata_nxt = r_mwdata;
        case (r_state)
            ST_IDLE: begin
                if (io_lsu.req) begin
                    w_we_nxt    = io_lsu.we;
                    w_size_nxt  = w_req_size;
                    w_uns_nxt   = ~io_lsu.we & io_lsu.funct3[2];
                    w_off_nxt   = io_lsu.addr[1:0];
                    w_wdata_nxt = io_lsu.wdata[15:0];
                    w_mis_nxt   = w_req_mis;
                    w_maddr_nxt = {io_lsu.addr[31:2], 2'b00};
                    if (w_req_mis) begin
                        w_state_nxt = ST_DONE;
                    end else if (io_lsu.we && (w_req_size == SZ_W)) begin
                        w_state_nxt  = ST_WR;
                        w_mwdata_nxt = io_lsu.wdata;
                    end else begin
                        w_state_nxt = ST_RD;
                    end
                end
            end
            ST_RD: begin
                if (r_we) begin
                    w_mwdata_nxt = lane_merge(io_lsu.mem_read_data, r_size, r_off, r_wdata);
                    w_state_nxt  = ST_WR;
                end else begin
                    w_rdata_nxt = lane_extract(io_lsu.mem_read_data, r_size, r_off, r_uns);
                    w_state_nxt = ST_DONE;
                end
            end
            ST_WR:   w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State and registered outputs; strobes are decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_we        <= 1'b0;
            r_size      <= SZ_W;
            r_uns       <= 1'b0;
            r_off       <= 2'b00;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_mis       <= 1'b0;
            r_maddr     <= '0;
            r_mwdata    <= '0;
            r_ready     <= 1'b1;
            r_done      <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_we        <= w_we_nxt;
            r_size      <= w_size_nxt;
            r_uns       <= w_uns_nxt;
            r_off       <= w_off_nxt;
            r_wdata     <= w_wdata_nxt;
            r_rdata     <= w_rdata_nxt;
            r_mis       <= w_mis_nxt;
            r_maddr     <= w_maddr_nxt;
            r_mwdata    <= w_mwdata_nxt;
            r_ready     <= (w_state_nxt == ST_IDLE);
            r_done      <= (w_state_nxt == ST_DONE);
            r_mem_read  <= (w_state_nxt == ST_RD);
            r_mem_write <= (w_state_nxt == ST_WR);
        end
    end

    assign io_lsu.ready          = r_ready;
    assign io_lsu.done           = r_done;
    assign io_lsu.rdata          = r_rdata;
    assign io_lsu.misaligned     = r_mis;
    assign io_lsu.mem_read       = r_mem_read;
    assign io_lsu.mem_write      = r_mem_write;
    assign io_lsu.mem_address    = r_maddr;
    assign io_lsu.mem_write_data = r_mwdata;
endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port with a word memory model and an expectation queue.
module tb_lsu_mem_port;
    logic clk = 1'b0;
    logic rst_n;
    logic mem_clr;
    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    lsu_mem_port_if bus ();

    lsu_mem_port dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_lsu (bus)
    );

    // Combinational read, write on the rising edge.
    assign bus.mem_read_data = mem[bus.mem_address[9:2]];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        end else if (bus.mem_write) begin
            mem[bus.mem_address[9:2]] <= bus.mem_write_data;
        end
    end

    typedef struct {
        string       tag;
        int          lat;
        int          rd_cyc;
        int          wr_cyc;
        logic        mis;
        logic [31:0] rdata;
        logic [31:0] mwdata;
        logic [31:0] maddr;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk;
    int   n_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one access when ready, track it cycle by cycle until done, then score it.
    task automatic do_op(input string tag, input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d,
                         input int lat, input int rd_cyc, input int wr_cyc, input logic mis,
                         input logic [31:0] rdata, input logic [31:0] mwdata, input bit perturb);
        exp_t e;
        exp_t g;
        int k, rd_n, wr_n, rd_at, wr_at, ov;
        logic [31:0] wd, ma;
        bit got;
        for (int i = 0; i < 8 && bus.ready !== 1'b1; i++) @(negedge clk);
        e.tag = tag; e.lat = lat; e.rd_cyc = rd_cyc; e.wr_cyc = wr_cyc; e.mis = mis;
        e.rdata = rdata; e.mwdata = mwdata; e.maddr = {a[31:2], 2'b00};
        sb_q.push_back(e);
        bus.req = 1'b1; bus.we = w; bus.funct3 = f3; bus.addr = a; bus.wdata = d;
        k = 0; rd_n = 0; wr_n = 0; rd_at = 0; wr_at = 0; ov = 0; wd = '0; ma = '0; got = 1'b0;
        while (!got && k < 12) begin
            @(negedge clk);
            k++;
            if (perturb && k == 1) begin
                bus.addr = a + 32'd4; bus.funct3 = 3'b000; bus.we = ~w;
            end
            if (bus.mem_read === 1'b1) begin rd_n++; rd_at = k; ma = bus.mem_address; end
            if (bus.mem_write === 1'b1) begin
                wr_n++; wr_at = k; wd = bus.mem_write_data; ma = bus.mem_address;
            end
            if (bus.mem_read === 1'b1 && bus.mem_write === 1'b1) ov++;
            if (bus.done === 1'b1) got = 1'b1;
        end
        bus.req = 1'b0;
        g = sb_q.pop_front();
        chk({g.tag, "/done_seen"}, 32'(got), 32'd1);
        if (got) begin
            chk({g.tag, "/latency"}, 32'(k), 32'(g.lat));
            chk({g.tag, "/rd_count"}, 32'(rd_n), 32'(g.rd_cyc != 0));
            chk({g.tag, "/rd_cycle"}, 32'(rd_at), 32'(g.rd_cyc));
            chk({g.tag, "/wr_count"}, 32'(wr_n), 32'(g.wr_cyc != 0));
            chk({g.tag, "/wr_cycle"}, 32'(wr_at), 32'(g.wr_cyc));
            chk({g.tag, "/rd_wr_overlap"}, 32'(ov), 32'd0);
            chk({g.tag, "/misaligned"}, 32'(bus.misaligned), 32'(g.mis));
            chk({g.tag, "/rdata"}, bus.rdata, g.rdata);
            if (g.wr_cyc != 0) chk({g.tag, "/mem_write_data"}, wd, g.mwdata);
            if (g.rd_cyc != 0 || g.wr_cyc != 0) chk({g.tag, "/mem_address"}, ma, g.maddr);
        end
    endtask

    initial begin
        int quiet;
        n_chk = 0; n_err = 0;
        bus.req = 1'b0; bus.we = 1'b0; bus.funct3 = 3'b000; bus.addr = '0; bus.wdata = '0;
        rst_n = 1'b0; mem_clr = 1'b1;
        repeat (3) @(negedge clk);
        mem_clr = 1'b0;

        chk("rst/ready", 32'(bus.ready), 32'd1);
        chk("rst/done", 32'(bus.done), 32'd0);
        chk("rst/rdata", bus.rdata, 32'h0);
        chk("rst/misaligned", 32'(bus.misaligned), 32'd0);
        chk("rst/mem_read", 32'(bus.mem_read), 32'd0);
        chk("rst/mem_write", 32'(bus.mem_write), 32'd0);
        chk("rst/mem_address", bus.mem_address, 32'h0);
        chk("rst/mem_write_data", bus.mem_write_data, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op("sw_100", 1'b1, 3'b010, 32'h100, 32'h8899AABB, 2, 0, 1, 1'b0, 32'h0, 32'h8899AABB, 1'b0);
        chk("mem_after_sw", mem[64], 32'h8899AABB);
        do_op("lw_100",  1'b0, 3'b010, 32'h100, 32'h0, 2, 1, 0, 1'b0, 32'h8899AABB, 32'h0, 1'b0);
        do_op("lb_103",  1'b0, 3'b000, 32'h103, 32'h0, 2, 1, 0, 1'b0, 32'hFFFFFF88, 32'h0, 1'b0);
        do_op("lbu_103", 1'b0, 3'b100, 32'h103, 32'h0, 2, 1, 0, 1'b0, 32'h00000088, 32'h0, 1'b0);
        do_op("lh_102",  1'b0, 3'b001, 32'h102, 32'h0, 2, 1, 0, 1'b0, 32'hFFFF8899, 32'h0, 1'b0);
        do_op("lhu_100", 1'b0, 3'b101, 32'h100, 32'h0, 2, 1, 0, 1'b0, 32'h0000AABB, 32'h0, 1'b0);

        do_op("sb_101", 1'b1, 3'b000, 32'h101, 32'hA5A5A511, 3, 1, 2, 1'b0, 32'h0000AABB, 32'h889911BB, 1'b0);
        chk("mem_after_sb", mem[64], 32'h889911BB);
        do_op("lw_after_sb", 1'b0, 3'b010, 32'h100, 32'h0, 2, 1, 0, 1'b0, 32'h889911BB, 32'h0, 1'b0);

`ifdef LSU_MISALIGN_TRAP_EN
        do_op("lw_102_trap", 1'b0, 3'b010, 32'h102, 32'h0, 1, 0, 0, 1'b1, 32'h889911BB, 32'h0, 1'b0);
`else
        do_op("lw_102_lane0", 1'b0, 3'b010, 32'h102, 32'h0, 2, 1, 0, 1'b0, 32'h889911BB, 32'h0, 1'b0);
`endif

        do_op("lw_perturb", 1'b0, 3'b010, 32'h100, 32'h0, 2, 1, 0, 1'b0, 32'h889911BB, 32'h0, 1'b1);
        quiet = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.mem_read === 1'b1 || bus.mem_write === 1'b1) quiet++;
        end
        chk("idle_after_perturb", 32'(quiet), 32'd0);

        do_op("sw_f3_111", 1'b1, 3'b111, 32'h104, 32'hDEADBEEF, 2, 0, 1, 1'b0, 32'h889911BB, 32'hDEADBEEF, 1'b0);
        do_op("lb_104",  1'b0, 3'b000, 32'h104, 32'h0, 2, 1, 0, 1'b0, 32'hFFFFFFEF, 32'h0, 1'b0);
        do_op("lhu_106", 1'b0, 3'b101, 32'h106, 32'h0, 2, 1, 0, 1'b0, 32'h0000DEAD, 32'h0, 1'b0);

        // sh abandoned by reset while in WR
        for (int i = 0; i < 8 && bus.ready !== 1'b1; i++) @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b1; bus.funct3 = 3'b001; bus.addr = 32'h100; bus.wdata = 32'h00001234;
        @(negedge clk);
        chk("rstwr/rd_phase", 32'(bus.mem_read), 32'd1);
        @(negedge clk);
        chk("rstwr/wr_phase", 32'(bus.mem_write), 32'd1);
        chk("rstwr/merged", bus.mem_write_data, 32'h88991234);
        #2;
        rst_n = 1'b0;
        bus.req = 1'b0;
        #1;
        chk("rstwr/mem_write_drop", 32'(bus.mem_write), 32'd0);
        chk("rstwr/ready", 32'(bus.ready), 32'd1);
        chk("rstwr/done", 32'(bus.done), 32'd0);
        chk("rstwr/rdata", bus.rdata, 32'h0);
        chk("rstwr/mem_address", bus.mem_address, 32'h0);
        chk("rstwr/mem_write_data", bus.mem_write_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstwr/mem_untouched", mem[64], 32'h889911BB);
        chk("rstwr/ready_after", 32'(bus.ready), 32'd1);

        do_op("sh_102", 1'b1, 3'b001, 32'h102, 32'hFFFF5678, 3, 1, 2, 1'b0, 32'h0, 32'h567811BB, 1'b0);
        do_op("lw_after_sh", 1'b0, 3'b010, 32'h100, 32'h0, 2, 1, 0, 1'b0, 32'h567811BB, 32'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
